ysyx_22050518_decode_stage: RTL and testbench

YSYX_22050518_DECODE_STAGE -- requirements
Module: ysyx_22050518_decode_stage

---
 rtl/ysyx_22050518_decode_stage_if.sv | 43 ++++
 rtl/ysyx_22050518_decode_stage.sv | 181 ++++++++++++++++++
 tb/tb_ysyx_22050518_decode_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050518_decode_stage_if.sv
// Handshake and payload bundle for the decode stage.
//   master : fetch/execute side. Drives in_valid/in_pc/in_inst, out_ready and flush.
//   slave  : decode stage. Drives in_ready and every out_* field.
interface ysyx_22050518_decode_stage_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_rd_wen;
  logic [XLEN-1:0] out_imm;
  logic [6:0]      out_alu_op;
  logic            out_alu_in1_pc;
  logic            out_alu_in2_imm;
  logic [9:0]      out_class;
  logic            out_ecall;
  logic            out_ebreak;
  logic            out_mret;
  logic [11:0]     out_csr_addr;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_rd_wen,
           out_imm, out_alu_op, out_alu_in1_pc, out_alu_in2_imm, out_class,
           out_ecall, out_ebreak, out_mret, out_csr_addr, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_rd_wen,
           out_imm, out_alu_op, out_alu_in1_pc, out_alu_in2_imm, out_class,
           out_ecall, out_ebreak, out_mret, out_csr_addr, out_illegal
  );
endinterface

// File: rtl/ysyx_22050518_decode_stage.sv
// RISC-V decode stage: decodes the offered instruction combinationally and
// queues the decoded fields (not the raw word) in a DEPTH-entry circular queue.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of ysyx_22050518_decode_stage_if
//              (flush, in_* fetch handshake, out_* execute handshake + fields)
// out_class is one-hot {r,i,l,s,b,jal,jalr,u,csr,sys}.
module ysyx_22050518_decode_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter bit HAS_M = 1'b1
) (
  input logic clk,
  input logic rst,
  ysyx_22050518_decode_stage_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam bit IS32 = (XLEN == 32);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_wen;
    logic [XLEN-1:0] imm;
    logic [6:0]      alu_op;
    logic            in1_pc;
    logic            in2_imm;
    logic [9:0]      cls;
    logic            ecall;
    logic            ebreak;
    logic            mret;
    logic [11:0]     csr_addr;
    logic            illegal;
  } dec_t;

  // ---------------- combinational decode ----------------
  logic [31:0] inst;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
  logic is_opimm, is_op, is_opimm32, is_op32, is_system;
  assign is_lui     = opcode == 7'b0110111;
  assign is_auipc   = opcode == 7'b0010111;
  assign is_jal     = opcode == 7'b1101111;
  assign is_jalr    = opcode == 7'b1100111;
  assign is_branch  = opcode == 7'b1100011;
  assign is_load    = opcode == 7'b0000011;
  assign is_store   = opcode == 7'b0100011;
  assign is_opimm   = opcode == 7'b0010011;
  assign is_op      = opcode == 7'b0110011;
  assign is_opimm32 = opcode == 7'b0011011;
  assign is_op32    = opcode == 7'b0111011;
  assign is_system  = opcode == 7'b1110011;

  logic known, is_ecall, is_ebreak, is_mret, is_m, is_sub, is_sra, illegal;
  assign known = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store |
                 is_opimm | is_op | is_opimm32 | is_op32 | is_system;
  assign is_ecall  = inst == 32'h0000_0073;
  assign is_ebreak = inst == 32'h0010_0073;
  assign is_mret   = inst == 32'h3020_0073;
  assign is_m      = (is_op | is_op32) && f7 == 7'b0000001;
  assign is_sub    = (is_op | is_op32) && f3 == 3'b000 && f7 == 7'b0100000;
  assign is_sra    = (is_op | is_opimm | is_op32 | is_opimm32) && f3 == 3'b101 &&
                     f7[6:1] == 6'b010000;

  // inst[25] is shamt[5] for OP-IMM shifts, which only exists on RV64.
  assign illegal = !known || inst[1:0] != 2'b11 ||
                   (IS32 && (is_op32 | is_opimm32)) ||
                   (IS32 && is_opimm && (f3 == 3'b001 || f3 == 3'b101) && inst[25]) ||
                   (!HAS_M && is_m) ||
                   (is_system && f3 == 3'b000 && !(is_ecall | is_ebreak | is_mret));

  logic [9:0] cls;
  assign cls = illegal ? 10'd0 :
               {is_op | is_op32, is_opimm | is_opimm32, is_load, is_store, is_branch,
                is_jal, is_jalr, is_lui | is_auipc, is_system && f3 != 3'b000,
                is_system && f3 == 3'b000};

  // Built at 64 bits and truncated so one expression covers RV32 and RV64.
  logic [63:0] imm64;
  always_comb begin
    imm64 = 64'd0;
    if (is_opimm | is_opimm32 | is_load | is_jalr)
      imm64 = {{52{inst[31]}}, inst[31:20]};
    else if (is_store)
      imm64 = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    else if (is_branch)
      imm64 = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    else if (is_jal)
      imm64 = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    else if (is_lui | is_auipc)
      imm64 = {{32{inst[31]}}, inst[31:12], 12'd0};
  end

  dec_t dec_in;
  always_comb begin
    dec_in          = '0;
    dec_in.pc       = bus.in_pc;
    dec_in.rs1      = is_ecall ? 5'd17 : inst[19:15];
    dec_in.rs2      = inst[24:20];
    dec_in.rd       = inst[11:7];
    dec_in.rd_wen   = |{cls[9:7], cls[4:1]};
    dec_in.imm      = imm64[XLEN-1:0];
    dec_in.alu_op   = is_auipc ? 7'b0100000 :
                      {is_op32 | is_opimm32, is_opimm | is_opimm32,
                       is_sub | is_m, is_sra | is_m, f3};
    dec_in.in1_pc   = cls[4] | cls[5];
    dec_in.in2_imm  = cls[8] | cls[5] | cls[4] | cls[3];
    dec_in.cls      = cls;
    dec_in.ecall    = !illegal && is_ecall;
    dec_in.ebreak   = !illegal && is_ebreak;
    dec_in.mret     = !illegal && is_mret;
    dec_in.csr_addr = inst[31:20];
    dec_in.illegal  = illegal;
  end

  // ---------------- queue ----------------
  dec_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, in_ready;

  assign in_ready = count < FULL;
  assign push     = bus.in_valid && in_ready && !bus.flush;
  assign pop      = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Payload needs no reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec_in;
  end

  dec_t head;
  assign head = mem[rd_ptr];

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = count != '0;
  assign bus.out_pc          = head.pc;
  assign bus.out_rs1         = head.rs1;
  assign bus.out_rs2         = head.rs2;
  assign bus.out_rd          = head.rd;
  assign bus.out_rd_wen      = head.rd_wen;
  assign bus.out_imm         = head.imm;
  assign bus.out_alu_op      = head.alu_op;
  assign bus.out_alu_in1_pc  = head.in1_pc;
  assign bus.out_alu_in2_imm = head.in2_imm;
  assign bus.out_class       = head.cls;
  assign bus.out_ecall       = head.ecall;
  assign bus.out_ebreak      = head.ebreak;
  assign bus.out_mret        = head.mret;
  assign bus.out_csr_addr    = head.csr_addr;
  assign bus.out_illegal     = head.illegal;

endmodule

// File: tb/tb_ysyx_22050518_decode_stage.sv
module tb_ysyx_22050518_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_22050518_decode_stage_if #(.XLEN(64)) b64 ();
  ysyx_22050518_decode_stage_if #(.XLEN(32)) b32 ();
  ysyx_22050518_decode_stage_if #(.XLEN(64)) bnm ();

  ysyx_22050518_decode_stage #(.XLEN(64), .DEPTH(2), .HAS_M(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(b64.slave));
  ysyx_22050518_decode_stage #(.XLEN(32), .DEPTH(2), .HAS_M(1'b1)) dut32 (
    .clk(clk), .rst(rst), .bus(b32.slave));
  ysyx_22050518_decode_stage #(.XLEN(64), .DEPTH(2), .HAS_M(1'b0)) dut_nm (
    .clk(clk), .rst(rst), .bus(bnm.slave));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push64(input logic [31:0] inst, input logic [63:0] pc);
    b64.in_valid = 1'b1;
    b64.in_inst  = inst;
    b64.in_pc    = pc;
    step();
    b64.in_valid = 1'b0;
  endtask

  task automatic pop64();
    b64.out_ready = 1'b1;
    step();
    b64.out_ready = 1'b0;
  endtask

  task automatic aux_push(input logic [31:0] inst);
    b32.in_valid = 1'b1;
    bnm.in_valid = 1'b1;
    b32.in_inst  = inst;
    bnm.in_inst  = inst;
    step();
    b32.in_valid = 1'b0;
    bnm.in_valid = 1'b0;
  endtask

  task automatic aux_pop();
    b32.out_ready = 1'b1;
    bnm.out_ready = 1'b1;
    step();
    b32.out_ready = 1'b0;
    bnm.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [6:0]  alu;
    logic [63:0] imm;
    logic [9:0]  cls;
    logic        wen;
    logic        in1;
    logic        in2;
    logic        ill;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{32'h00500093, 7'b0100000, 64'd5,                  10'h100, 1'b1, 1'b0, 1'b1, 1'b0}; // addi
    tbl[1]  = '{32'hFFF00113, 7'b0100000, 64'hFFFF_FFFF_FFFF_FFFF, 10'h100, 1'b1, 1'b0, 1'b1, 1'b0}; // addi -1
    tbl[2]  = '{32'h022081B3, 7'b0011000, 64'd0,                  10'h200, 1'b1, 1'b0, 1'b0, 1'b0}; // mul
    tbl[3]  = '{32'h40208133, 7'b0010000, 64'd0,                  10'h200, 1'b1, 1'b0, 1'b0, 1'b0}; // sub
    tbl[4]  = '{32'h4030D093, 7'b0101101, 64'h403,                10'h100, 1'b1, 1'b0, 1'b1, 1'b0}; // srai
    tbl[5]  = '{32'h00001097, 7'b0100000, 64'h1000,               10'h004, 1'b1, 1'b0, 1'b0, 1'b0}; // auipc
    tbl[6]  = '{32'hFE000EE3, 7'b0000000, 64'hFFFF_FFFF_FFFF_FFFC, 10'h020, 1'b0, 1'b1, 1'b1, 1'b0}; // beq -4
    tbl[7]  = '{32'h00000073, 7'b0000000, 64'd0,                  10'h001, 1'b0, 1'b0, 1'b0, 1'b0}; // ecall
    tbl[8]  = '{32'h10500073, 7'b0000000, 64'd0,                  10'h000, 1'b0, 1'b0, 1'b0, 1'b1}; // wfi
    tbl[9]  = '{32'h00000000, 7'b0000000, 64'd0,                  10'h000, 1'b0, 1'b0, 1'b0, 1'b1}; // zero word
    tbl[10] = '{32'h008000EF, 7'b0000000, 64'd8,                  10'h010, 1'b1, 1'b1, 1'b1, 1'b0}; // jal +8
    tbl[11] = '{32'h800002B7, 7'b0000000, 64'hFFFF_FFFF_8000_0000, 10'h004, 1'b1, 1'b0, 1'b0, 1'b0}; // lui
    tbl[12] = '{32'h300110F3, 7'b0000001, 64'd0,                  10'h002, 1'b1, 1'b0, 1'b0, 1'b0}; // csrrw
    tbl[13] = '{32'h0010009B, 7'b1100000, 64'd1,                  10'h100, 1'b1, 1'b0, 1'b1, 1'b0}; // addiw
  end

  initial begin
    b64.flush = 0; b64.in_valid = 0; b64.in_pc = '0; b64.in_inst = '0; b64.out_ready = 0;
    b32.flush = 0; b32.in_valid = 0; b32.in_pc = '0; b32.in_inst = '0; b32.out_ready = 0;
    bnm.flush = 0; bnm.in_valid = 0; bnm.in_pc = '0; bnm.in_inst = '0; bnm.out_ready = 0;

    step();
    chk("rst_out_valid", b64.out_valid, 1'b0);
    chk("rst_in_ready", b64.in_ready, 1'b1);
    step();
    rst = 1'b0;
    step();

    // first push: one cycle latency
    b64.in_valid = 1'b1; b64.in_inst = 32'h00500093; b64.in_pc = 64'h1000;
    #1 chk("lat_pre", b64.out_valid, 1'b0);
    step();
    b64.in_valid = 1'b0;
    chk("addi_valid", b64.out_valid, 1'b1);
    chk("addi_rd", b64.out_rd, 5'd1);
    chk("addi_rs1", b64.out_rs1, 5'd0);
    chk("addi_pc", b64.out_pc, 64'h1000);
    pop64();
    chk("addi_popped", b64.out_valid, 1'b0);

    // decode table
    foreach (tbl[i]) begin
      push64(tbl[i].inst, 64'h4000 + 64'(i * 4));
      chk($sformatf("v%0d_valid", i), b64.out_valid, 1'b1);
      chk($sformatf("v%0d_alu", i), b64.out_alu_op, tbl[i].alu);
      chk($sformatf("v%0d_imm", i), b64.out_imm, tbl[i].imm);
      chk($sformatf("v%0d_cls", i), b64.out_class, tbl[i].cls);
      chk($sformatf("v%0d_flags", i),
          {b64.out_rd_wen, b64.out_alu_in1_pc, b64.out_alu_in2_imm, b64.out_illegal},
          {tbl[i].wen, tbl[i].in1, tbl[i].in2, tbl[i].ill});
      pop64();
    end

    // system ops and csr address
    push64(32'h00000073, 64'h50);
    chk("ecall_flag", {b64.out_ecall, b64.out_ebreak, b64.out_mret}, 3'b100);
    chk("ecall_rs1", b64.out_rs1, 5'd17);
    pop64();
    push64(32'h00100073, 64'h54);
    chk("ebreak_flag", {b64.out_ecall, b64.out_ebreak, b64.out_mret}, 3'b010);
    chk("ebreak_rs1", b64.out_rs1, 5'd0);
    pop64();
    push64(32'h30200073, 64'h58);
    chk("mret_flag", {b64.out_ecall, b64.out_ebreak, b64.out_mret}, 3'b001);
    pop64();
    push64(32'h10500073, 64'h5C);
    chk("wfi_flags", {b64.out_ecall, b64.out_ebreak, b64.out_mret}, 3'b000);
    pop64();
    push64(32'h300110F3, 64'h60);
    chk("csr_addr", b64.out_csr_addr, 12'h300);
    chk("csr_rs1", b64.out_rs1, 5'd2);
    pop64();

    // fill, backpressure, order, wrap
    push64(32'h00500093, 64'h100);
    chk("fill1_ready", b64.in_ready, 1'b1);
    push64(32'hFFF00113, 64'h104);
    chk("full_ready", b64.in_ready, 1'b0);
    b64.in_valid = 1'b1; b64.in_inst = 32'h022081B3; b64.in_pc = 64'h108;
    step();
    chk("held_ready", b64.in_ready, 1'b0);
    chk("held_pc", b64.out_pc, 64'h100);
    chk("held_imm", b64.out_imm, 64'd5);
    b64.out_ready = 1'b1;
    step();
    b64.out_ready = 1'b0;
    chk("pop1_ready", b64.in_ready, 1'b1);
    chk("pop1_pc", b64.out_pc, 64'h104);
    chk("pop1_rd", b64.out_rd, 5'd2);
    chk("pop1_imm", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    b64.in_valid = 1'b0;
    chk("refill_ready", b64.in_ready, 1'b0);
    b64.out_ready = 1'b1;
    step();
    chk("pop2_pc", b64.out_pc, 64'h108);
    chk("pop2_alu", b64.out_alu_op, 7'b0011000);
    // simultaneous push and pop with one entry held
    b64.in_valid = 1'b1; b64.in_inst = 32'h40208133; b64.in_pc = 64'h10C;
    step();
    b64.in_valid = 1'b0;
    chk("pp_valid", b64.out_valid, 1'b1);
    chk("pp_pc", b64.out_pc, 64'h10C);
    chk("pp_ready", b64.in_ready, 1'b1);
    step();
    b64.out_ready = 1'b0;
    chk("drained", b64.out_valid, 1'b0);

    // flush with full queue and same-cycle offer
    push64(32'h00500093, 64'h200);
    push64(32'hFFF00113, 64'h204);
    b64.flush = 1'b1; b64.in_valid = 1'b1; b64.in_inst = 32'h00000073; b64.in_pc = 64'h208;
    step();
    b64.flush = 1'b0; b64.in_valid = 1'b0;
    chk("flush_valid", b64.out_valid, 1'b0);
    chk("flush_ready", b64.in_ready, 1'b1);
    // flush with room: the offered push must be dropped
    push64(32'h00500093, 64'h210);
    b64.flush = 1'b1; b64.in_valid = 1'b1; b64.in_inst = 32'h00000073; b64.in_pc = 64'h214;
    step();
    b64.flush = 1'b0; b64.in_valid = 1'b0;
    chk("flush2_valid", b64.out_valid, 1'b0);
    step();
    chk("flush2_absent", b64.out_valid, 1'b0);
    push64(32'h00500093, 64'h220);
    chk("post_flush_pc", b64.out_pc, 64'h220);
    pop64();

    // XLEN=32 and HAS_M=0 variants
    aux_push(32'h0010009B);
    chk("rv32_addiw_ill", b32.out_illegal, 1'b1);
    chk("rv32_addiw_wen", b32.out_rd_wen, 1'b0);
    chk("rv32_addiw_cls", b32.out_class, 10'd0);
    chk("nm_addiw_ill", bnm.out_illegal, 1'b0);
    aux_pop();
    aux_push(32'h02009093);
    chk("rv32_slli32_ill", b32.out_illegal, 1'b1);
    chk("nm_slli32_ill", bnm.out_illegal, 1'b0);
    chk("nm_slli32_alu", bnm.out_alu_op, 7'b0100001);
    aux_pop();
    aux_push(32'h022081B3);
    chk("rv32_mul_ill", b32.out_illegal, 1'b0);
    chk("rv32_mul_alu", b32.out_alu_op, 7'b0011000);
    chk("nm_mul_ill", bnm.out_illegal, 1'b1);
    chk("nm_mul_cls", bnm.out_class, 10'd0);
    chk("nm_mul_wen", bnm.out_rd_wen, 1'b0);
    aux_pop();
    aux_push(32'hFFF00113);
    chk("rv32_imm", b32.out_imm, 64'h0000_0000_FFFF_FFFF);
    aux_pop();
    chk("aux_drained", b32.out_valid, 1'b0);

    // reset mid-operation
    push64(32'h00500093, 64'h300);
    push64(32'hFFF00113, 64'h304);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", b64.out_valid, 1'b0);
    chk("midrst_ready", b64.in_ready, 1'b1);
    step();
    rst = 1'b0;
    step();
    chk("postrst_valid", b64.out_valid, 1'b0);
    push64(32'h00000073, 64'h310);
    chk("postrst_push", b64.out_valid, 1'b1);
    chk("postrst_pc", b64.out_pc, 64'h310);
    chk("postrst_ecall", b64.out_ecall, 1'b1);
    pop64();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
